// File: rtl/router_pkg.sv
// Shared widths and address constants for the router datapath.
// Also provides the header address check used by the register block.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // True when the header's low bits name a real destination.
  function automatic logic addr_ok(input logic [DATA_W-1:0] hdr);
    return hdr[ADDR_W-1:0] != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity.sv
// Running parity over header and payload, compared against the trailing parity byte.
// The error flag is registered when the controller strobes rst_int_reg.
module router_parity
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              rst_int_reg,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] header_byte,
  output logic              err
);

  logic [DATA_W-1:0] internal_parity;
  logic [DATA_W-1:0] packet_parity;

  always_ff @(posedge clock) begin
    if (reset) begin
      internal_parity <= '0;
      packet_parity   <= '0;
      err             <= 1'b0;
    end else begin
      // Payload bytes count even when stalled; the replay in laf_state is not re-accumulated.
      if (detect_add)
        internal_parity <= '0;
      else if (lfd_state)
        internal_parity <= internal_parity ^ header_byte;
      else if (ld_state && pkt_valid)
        internal_parity <= internal_parity ^ data_in;

      if (ld_state && !pkt_valid)
        packet_parity <= data_in;

      if (detect_add)
        err <= 1'b0;
      else if (rst_int_reg)
        err <= (internal_parity != packet_parity);
    end
  end

endmodule

// File: rtl/router_reg.sv
// Router register block: header latch, FIFO-facing data mux with stall buffer,
// and packet status flags. Parity checking is in router_parity.
module router_reg
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err
);

  logic [DATA_W-1:0] header_byte;
  logic [DATA_W-1:0] hold_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      header_byte      <= '0;
      hold_byte        <= '0;
      dout             <= '0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
    end else begin
      if (detect_add && pkt_valid && addr_ok(data_in))
        header_byte <= data_in;

      // A byte that meets a full FIFO is parked in hold_byte and replayed in laf_state.
      if (lfd_state)
        dout <= header_byte;
      else if (ld_state) begin
        if (!fifo_full)
          dout <= data_in;
        else
          hold_byte <= data_in;
      end else if (laf_state)
        dout <= hold_byte;
      else if (full_state)
        dout <= dout;

      if (ld_state && !pkt_valid)
        low_packet_valid <= 1'b1;
      else if (rst_int_reg)
        low_packet_valid <= 1'b0;

      if (detect_add)
        parity_done <= 1'b0;
      else if (ld_state && !fifo_full && !pkt_valid)
        parity_done <= 1'b1;
      else if (laf_state && low_packet_valid && !parity_done)
        parity_done <= 1'b1;
    end
  end

  router_parity u_parity (
    .clock       (clock),
    .reset       (reset),
    .detect_add  (detect_add),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .rst_int_reg (rst_int_reg),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .header_byte (header_byte),
    .err         (err)
  );

endmodule

// File: tb/tb_router_reg.sv
// Packet-level bench for router_reg: emulates the controller strobe sequence,
// queues expected outputs per cycle and checks them from a negedge monitor.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       reset, pkt_valid, fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in, dout;
  logic       parity_done, low_packet_valid, err;

  always #5 clock = ~clock;

  router_reg dut (
    .clock            (clock),
    .reset            (reset),
    .pkt_valid        (pkt_valid),
    .data_in          (data_in),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .dout             (dout),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err)
  );

  typedef struct packed {
    logic [7:0] dout;
    logic       pd;
    logic       lpv;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_dout, m_hdr;
  logic       m_pd, m_lpv, m_err;
  logic [7:0] pl[0:63];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dout", dout, e.dout);
      chk("parity_done", parity_done, e.pd);
      chk("low_packet_valid", low_packet_valid, e.lpv);
      chk("err", err, e.err);
    end
  end

  task automatic idle();
    pkt_valid = 0; fifo_full = 0; data_in = 8'h00;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0;
  endtask

  // One clock with the current inputs; the model values are what the outputs must show after it.
  task automatic cyc();
    exp_t e;
    @(posedge clock);
    e.dout = m_dout; e.pd = m_pd; e.lpv = m_lpv; e.err = m_err;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  // FIFO stays full for len cycles, then the parked byte b is delivered.
  task automatic stall(input int len, input logic [7:0] b, input logic is_parity);
    for (int k = 0; k < len; k++) begin
      idle(); full_state = 1; fifo_full = 1; cyc();
    end
    idle(); laf_state = 1; m_dout = b;
    if (is_parity) m_pd = 1;
    cyc();
  endtask

  task automatic invalid_detect(input logic [7:0] b);
    idle(); detect_add = 1; pkt_valid = 1; data_in = b;
    m_pd = 0; m_err = 0;
    cyc();
  endtask

  task automatic lone_lfd();
    idle(); lfd_state = 1; pkt_valid = 1; m_dout = m_hdr; cyc();
  endtask

  task automatic send_packet(input logic [7:0] hdr, input int n, input logic [7:0] par,
                             input int stall_mask, input int stall_len, input int reset_at);
    logic [7:0] sum;
    idle(); detect_add = 1; pkt_valid = 1; data_in = hdr;
    if (hdr[1:0] != 2'b11) m_hdr = hdr;
    m_pd = 0; m_err = 0;
    cyc();
    idle(); lfd_state = 1; pkt_valid = 1; data_in = hdr; m_dout = m_hdr; cyc();
    sum = m_hdr;
    for (int i = 0; i < n; i++) begin
      idle(); ld_state = 1; pkt_valid = 1; data_in = pl[i]; fifo_full = stall_mask[i];
      sum ^= pl[i];
      if (reset_at == i) begin
        reset = 1;
        m_dout = 0; m_pd = 0; m_lpv = 0; m_err = 0; m_hdr = 0;
        cyc();
        reset = 0; idle();
        return;
      end
      if (!stall_mask[i]) begin
        m_dout = pl[i]; cyc();
      end else begin
        cyc(); stall(stall_len, pl[i], 1'b0);
      end
    end
    idle(); ld_state = 1; pkt_valid = 0; data_in = par; fifo_full = stall_mask[n];
    m_lpv = 1;
    if (!stall_mask[n]) begin
      m_dout = par; m_pd = 1; cyc();
    end else begin
      cyc(); stall(stall_len, par, 1'b1);
    end
    idle(); rst_int_reg = 1; m_lpv = 0; m_err = (sum != par); cyc();
    idle(); cyc();
  endtask

  initial begin
    int         n, sl, ra;
    logic [7:0] hdr, par, sum;
    idle(); reset = 1;
    m_dout = 0; m_pd = 0; m_lpv = 0; m_err = 0; m_hdr = 0;
    cyc(); cyc();
    reset = 0;

    // Invalid address straight after reset: nothing moves, header stays 0.
    invalid_detect(8'h0F);
    lone_lfd();
    idle(); cyc();

    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_packet(8'h0D, 3, 8'h0D, 0, 0, -1);        // good packet
    send_packet(8'h0D, 3, 8'h0C, 0, 0, -1);        // bad parity
    idle(); cyc(); cyc();                           // err must hold
    send_packet(8'h0D, 3, 8'h0D, 32'b0010, 2, -1); // stall on 0x22
    send_packet(8'h0D, 3, 8'h0D, 32'b1000, 1, -1); // parity byte while full
    invalid_detect(8'h0F);                          // header 0D retained
    lone_lfd();
    send_packet(8'h0D, 3, 8'h0D, 0, 0, 1);          // reset mid-packet
    lone_lfd();                                      // header cleared by reset
    send_packet(8'h0D, 3, 8'h0D, 0, 0, -1);

    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      hdr = {n[5:0], 2'($urandom_range(0, 2))};
      sum = hdr;
      for (int i = 0; i < n; i++) begin
        pl[i] = 8'($urandom);
        sum ^= pl[i];
      end
      par = ($urandom_range(0, 3) == 0) ? 8'($urandom) : sum;
      sl = $urandom_range(0, 2);
      ra = ($urandom_range(0, 9) == 0) ? $urandom_range(0, n - 1) : -1;
      if ($urandom_range(0, 4) == 0) invalid_detect({6'($urandom), 2'b11});
      send_packet(hdr, n, par, int'($urandom & $urandom), sl, ra);
    end

    idle();
    repeat (3) @(negedge clock);
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
